// File: rtl/rpm_meas_sched_if.sv
// Result handshake between the tachometer scheduler (master) and the display logic (slave).
interface rpm_meas_sched_if #(
  parameter int CH_W = 1
);
  logic            res_valid;
  logic            res_ready;
  logic [7:0]      res_data;
  logic [CH_W-1:0] res_ch;
  logic            res_sat;

  modport master (output res_valid, res_data, res_ch, res_sat, input res_ready);
  modport slave  (input res_valid, res_data, res_ch, res_sat, output res_ready);
endinterface

// File: rtl/rpm_meas_sched.sv
// Round-robin pulse-count tachometer scheduler: one synchronizer/edge detector/counter
// shared across NCH active-low pulse sources, one gated measurement per channel.
module rpm_meas_sched #(
  parameter int NCH           = 2,
  parameter int CH_W          = 1,
  parameter int GATE_CYCLES   = 50000000,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 13,
  parameter int SHIFT         = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [NCH-1:0]   pulse_n,
  rpm_meas_sched_if.master res,
  output logic [CH_W-1:0]  cur_ch,
  output logic             gate_active,
  output logic             busy
);

  localparam int TMAX  = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TIM_W = $clog2(TMAX + 1);

  localparam logic [TIM_W-1:0] SETTLE_LOAD = TIM_W'(SETTLE_CYCLES - 1);
  localparam logic [TIM_W-1:0] GATE_LOAD   = TIM_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CH_W-1:0]  LAST_CH     = CH_W'(NCH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_GATE,
    S_SCALE,
    S_PRESENT
  } state_e;

  state_e           state_q, state_d;
  logic [TIM_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic             valid_q, valid_d;
  logic [7:0]       data_q, data_d;
  logic [CH_W-1:0]  rch_q, rch_d;
  logic             sat_q, sat_d;
  logic             sync1_q, sync2_q, hist_q;

  logic             pulse_edge;
  logic [CNT_W-1:0] scaled;
  logic             scaled_big;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= ~pulse_n[ch_q];
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign pulse_edge = sync2_q & ~hist_q;
  assign scaled     = count_q >> SHIFT;
  assign scaled_big = |(scaled >> 8);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      rch_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      rch_q   <= rch_d;
      sat_q   <= sat_d;
    end
  end

  // NOTE: every signal gets its hold value first, so no branch can leave one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    data_d  = data_q;
    rch_d   = rch_q;
    sat_d   = sat_q;

    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_SETTLE;
          timer_d = SETTLE_LOAD;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      S_SETTLE: begin
        if (!enable) begin
          state_d = S_IDLE;
          count_d = '0;
          ovf_d   = 1'b0;
        end else if (timer_q == '0) begin
          state_d = S_GATE;
          timer_d = GATE_LOAD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_GATE: begin
        if (!enable) begin
          state_d = S_IDLE;
          count_d = '0;
          ovf_d   = 1'b0;
        end else begin
          // Counter sticks at full scale; ovf marks that the true count may be higher.
          if (pulse_edge && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
            if (count_q == CNT_MAX - 1'b1) ovf_d = 1'b1;
          end
          if (timer_q == '0) state_d = S_SCALE;
          else               timer_d = timer_q - 1'b1;
        end
      end
      S_SCALE: begin
        state_d = S_PRESENT;
        valid_d = 1'b1;
        data_d  = scaled_big ? 8'hFF : 8'(scaled);
        sat_d   = ovf_q | scaled_big;
        rch_d   = ch_q;
      end
      S_PRESENT: begin
        if (res.res_ready) begin
          valid_d = 1'b0;
          ch_d    = (ch_q == LAST_CH) ? '0 : ch_q + 1'b1;
          if (enable) begin
            state_d = S_SETTLE;
            timer_d = SETTLE_LOAD;
            count_d = '0;
            ovf_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign res.res_valid = valid_q;
  assign res.res_data  = data_q;
  assign res.res_ch    = rch_q;
  assign res.res_sat   = sat_q;
  assign cur_ch        = ch_q;
  assign gate_active   = (state_q == S_GATE);
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_rpm_meas_sched.sv
// Directed bench for rpm_meas_sched: dut_a uses GATE=100/SHIFT=2, dut_b GATE=1000/SHIFT=0.
module tb_rpm_meas_sched;
  localparam int NCH  = 2;
  localparam int CH_W = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic            en_a = 1'b0, en_b = 1'b0;
  logic [NCH-1:0]  pn_a = '1, pn_b = '1;
  logic [CH_W-1:0] ch_a, ch_b;
  logic            gate_a, gate_b, busy_a, busy_b;

  rpm_meas_sched_if #(.CH_W(CH_W)) if_a ();
  rpm_meas_sched_if #(.CH_W(CH_W)) if_b ();

  rpm_meas_sched #(.NCH(NCH), .CH_W(CH_W), .GATE_CYCLES(100), .SETTLE_CYCLES(4),
                   .CNT_W(13), .SHIFT(2)) dut_a (
    .clk(clk), .reset(reset), .enable(en_a), .pulse_n(pn_a), .res(if_a.master),
    .cur_ch(ch_a), .gate_active(gate_a), .busy(busy_a));

  rpm_meas_sched #(.NCH(NCH), .CH_W(CH_W), .GATE_CYCLES(1000), .SETTLE_CYCLES(4),
                   .CNT_W(13), .SHIFT(0)) dut_b (
    .clk(clk), .reset(reset), .enable(en_b), .pulse_n(pn_b), .res(if_b.master),
    .cur_ch(ch_b), .gate_active(gate_b), .busy(busy_b));

  int n_checks = 0;
  int n_fail   = 0;
  int t_gate   = 0;

  task automatic wait_gate_a(input int budget);
    int i = 0;
    while (!gate_a && i < budget) begin
      @(negedge clk);
      i++;
    end
    t_gate = cyc;
    n_checks++;
    if (gate_a !== 1'b1) begin
      n_fail++;
      $display("FAIL gate_start_timeout: gate_active=%b required 1", gate_a);
    end
  endtask

  task automatic wait_valid_a(input int budget);
    int i = 0;
    while (!if_a.res_valid && i < budget) begin
      @(negedge clk);
      i++;
    end
    n_checks++;
    if (if_a.res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL valid_timeout: res_valid=%b required 1", if_a.res_valid);
    end
  endtask

  // Active-low pulses: low for one cycle, then high for period-1 cycles.
  task automatic drive_a(input int ch, input int n, input int period);
    for (int i = 0; i < n; i++) begin
      pn_a[ch] = 1'b0;
      @(negedge clk);
      pn_a[ch] = 1'b1;
      repeat (period - 1) @(negedge clk);
    end
  endtask

  task automatic drive_b(input int ch, input int n, input int period);
    for (int i = 0; i < n; i++) begin
      pn_b[ch] = 1'b0;
      @(negedge clk);
      pn_b[ch] = 1'b1;
      repeat (period - 1) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #2 reset = 1'b0;
    #2;
    n_checks++;
    if ({if_a.res_valid, if_a.res_data, if_a.res_ch, if_a.res_sat, ch_a, gate_a, busy_a} !== '0) begin
      n_fail++;
      $display("FAIL reset_a: valid=%b data=%0d ch=%b sat=%b cur=%b gate=%b busy=%b required all 0",
               if_a.res_valid, if_a.res_data, if_a.res_ch, if_a.res_sat, ch_a, gate_a, busy_a);
    end
    n_checks++;
    if ({if_b.res_valid, if_b.res_data, if_b.res_ch, if_b.res_sat, ch_b, gate_b, busy_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_b: valid=%b data=%0d sat=%b busy=%b required all 0",
               if_b.res_valid, if_b.res_data, if_b.res_sat, busy_b);
    end
    @(negedge clk);
    reset = 1'b1;
    if_a.res_ready = 1'b1;
    if_b.res_ready = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_ch0;
    en_a = 1'b1;
    wait_gate_a(20);
    repeat (4) @(negedge clk);
    drive_a(0, 40, 2);
    wait_valid_a(200);
    n_checks++;
    if (cyc - t_gate !== 101) begin
      n_fail++;
      $display("FAIL basic_latency: cycles=%0d required 101", cyc - t_gate);
    end
    n_checks++;
    if ({if_a.res_data, if_a.res_ch, if_a.res_sat} !== {8'd10, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_result: data=%0d ch=%b sat=%b required 10/0/0",
               if_a.res_data, if_a.res_ch, if_a.res_sat);
    end
    @(negedge clk);
    n_checks++;
    if ({if_a.res_valid, ch_a, busy_a, gate_a} !== 4'b0110) begin
      n_fail++;
      $display("FAIL basic_advance: valid=%b cur=%b busy=%b gate=%b required 0/1/1/0",
               if_a.res_valid, ch_a, busy_a, gate_a);
    end
  endtask

  task automatic test_settle_ignore_ch1;
    // Entered on the first SETTLE cycle of ch1.
    drive_a(1, 3, 2);
    wait_gate_a(20);
    repeat (2) @(negedge clk);
    drive_a(1, 8, 2);
    wait_valid_a(200);
    n_checks++;
    if ({if_a.res_data, if_a.res_ch, if_a.res_sat} !== {8'd2, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL settle_result: data=%0d ch=%b sat=%b required 2/1/0",
               if_a.res_data, if_a.res_ch, if_a.res_sat);
    end
    @(negedge clk);
    n_checks++;
    if ({if_a.res_valid, ch_a} !== 2'b00) begin
      n_fail++;
      $display("FAIL settle_wrap: valid=%b cur=%b required 0/0", if_a.res_valid, ch_a);
    end
  endtask

  task automatic test_back_pressure;
    wait_valid_a(200);
    n_checks++;
    if ({if_a.res_data, if_a.res_ch, if_a.res_sat} !== {8'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL bp_zero: data=%0d ch=%b sat=%b required 0/0/0",
               if_a.res_data, if_a.res_ch, if_a.res_sat);
    end
    @(negedge clk);
    if_a.res_ready = 1'b0;
    wait_gate_a(20);
    repeat (4) @(negedge clk);
    drive_a(1, 12, 2);
    wait_valid_a(200);
    for (int i = 0; i < 50; i++) begin
      pn_a[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
      n_checks++;
      if ({if_a.res_valid, if_a.res_data, if_a.res_ch, if_a.res_sat, gate_a, ch_a}
          !== {1'b1, 8'd3, 1'b1, 1'b0, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%0d ch=%b sat=%b gate=%b cur=%b required 1/3/1/0/0/1",
                 i, if_a.res_valid, if_a.res_data, if_a.res_ch, if_a.res_sat, gate_a, ch_a);
      end
      @(negedge clk);
    end
    pn_a[1] = 1'b1;
    if_a.res_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({if_a.res_valid, ch_a} !== 2'b00) begin
      n_fail++;
      $display("FAIL bp_release: valid=%b cur=%b required 0/0", if_a.res_valid, ch_a);
    end
  endtask

  task automatic test_enable_drop;
    wait_gate_a(20);
    repeat (4) @(negedge clk);
    drive_a(0, 20, 2);
    repeat (6) @(negedge clk);
    en_a = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy_a, gate_a, if_a.res_valid, ch_a} !== 4'b0000) begin
      n_fail++;
      $display("FAIL drop_idle: busy=%b gate=%b valid=%b cur=%b required 0/0/0/0",
               busy_a, gate_a, if_a.res_valid, ch_a);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if ({busy_a, if_a.res_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL drop_stay: busy=%b valid=%b required 0/0", busy_a, if_a.res_valid);
    end
    en_a = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy_a, gate_a, ch_a} !== 3'b100) begin
      n_fail++;
      $display("FAIL drop_restart: busy=%b gate=%b cur=%b required 1/0/0", busy_a, gate_a, ch_a);
    end
    wait_gate_a(20);
    repeat (4) @(negedge clk);
    drive_a(0, 4, 2);
    wait_valid_a(200);
    n_checks++;
    if ({if_a.res_data, if_a.res_ch} !== {8'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL drop_result: data=%0d ch=%b required 1/0", if_a.res_data, if_a.res_ch);
    end
    @(negedge clk);
    n_checks++;
    if (ch_a !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_advance: cur=%b required 1", ch_a);
    end
  endtask

  task automatic test_reset_mid_run;
    wait_gate_a(20);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    en_a  = 1'b0;
    #1;
    n_checks++;
    if ({if_a.res_valid, if_a.res_data, if_a.res_ch, if_a.res_sat, ch_a, gate_a, busy_a} !== '0) begin
      n_fail++;
      $display("FAIL rst_gate: valid=%b data=%0d cur=%b gate=%b busy=%b required all 0",
               if_a.res_valid, if_a.res_data, ch_a, gate_a, busy_a);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy_a, ch_a} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_gate_idle: busy=%b cur=%b required 0/0", busy_a, ch_a);
    end
    en_a = 1'b1;
    wait_valid_a(200);
    @(negedge clk);
    if_a.res_ready = 1'b0;
    wait_gate_a(20);
    repeat (4) @(negedge clk);
    drive_a(1, 20, 2);
    wait_valid_a(200);
    n_checks++;
    if ({if_a.res_data, if_a.res_ch} !== {8'd5, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_pre_result: data=%0d ch=%b required 5/1", if_a.res_data, if_a.res_ch);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({if_a.res_valid, if_a.res_data, if_a.res_ch, if_a.res_sat, ch_a, gate_a, busy_a} !== '0) begin
      n_fail++;
      $display("FAIL rst_present: valid=%b data=%0d ch=%b cur=%b busy=%b required all 0",
               if_a.res_valid, if_a.res_data, if_a.res_ch, ch_a, busy_a);
    end
    @(negedge clk);
    reset = 1'b1;
    en_a  = 1'b0;
    if_a.res_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy_a, if_a.res_valid, ch_a} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_present_idle: busy=%b valid=%b cur=%b required 0/0/0",
               busy_a, if_a.res_valid, ch_a);
    end
  endtask

  task automatic test_saturate;
    int i;
    en_b = 1'b1;
    i = 0;
    while (!gate_b && i < 30) begin
      @(negedge clk);
      i++;
    end
    n_checks++;
    if (gate_b !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_gate_timeout: gate_active=%b required 1", gate_b);
    end
    repeat (4) @(negedge clk);
    drive_b(0, 300, 3);
    i = 0;
    while (!if_b.res_valid && i < 300) begin
      @(negedge clk);
      i++;
    end
    n_checks++;
    if ({if_b.res_valid, if_b.res_data, if_b.res_sat, if_b.res_ch} !== {1'b1, 8'd255, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL sat_result: valid=%b data=%0d sat=%b ch=%b required 1/255/1/0",
               if_b.res_valid, if_b.res_data, if_b.res_sat, if_b.res_ch);
    end
    en_b = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    if_a.res_ready = 1'b1;
    if_b.res_ready = 1'b1;
    test_reset();
    test_basic_ch0();
    test_settle_ignore_ch1();
    test_back_pressure();
    test_enable_drop();
    test_reset_mid_run();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rpm_meas_sched.md
Name: rpm_meas_sched

Overview:
- Scheduler for the pulse-count tachometer datapath on the moto display.
- Shares one synchronizer, edge detector and pulse counter round-robin among NCH active-low pulse sources (ignition coil, wheel sensor, ...).
- Sequences each measurement: mux settle, timed gate window, scale/saturate, then hands an 8-bit result to the display logic over a valid/ready handshake.

Parameters:
- NCH, 2, number of pulse channels (2..8).
- CH_W, 1, channel index width; must satisfy 2^CH_W >= NCH.
- GATE_CYCLES, 50000000, gate window length in clk cycles (1 s at 50 MHz).
- SETTLE_CYCLES, 4, synchronizer flush cycles after a channel switch; minimum 3.
- CNT_W, 13, pulse counter width.
- SHIFT, 5, right shift applied to the count (divide by 32).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low.
- enable  in  1  run scheduler.
- pulse_n  in  NCH  raw active-low pulse inputs, asynchronous to clk.
- res_ready  in  1  display accepts result.
- res_valid  out  1  result available.
- res_data  out  8  scaled count.
- res_ch  out  CH_W  channel of the result.
- res_sat  out  1  result clipped to 255 or counter saturated.
- cur_ch  out  CH_W  channel currently routed to the counter.
- gate_active  out  1  high during GATE.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset: state IDLE; cur_ch=0; counter=0; all outputs 0.
- Reset is asynchronous in every state, including mid-gate and mid-handshake; pending results are discarded.
- Input path: sample ~pulse_n[cur_ch] through a 2-flop synchronizer plus a history flop. An edge is a 0->1 transition of the inverted, synchronized signal.
- Edges count only in cycles where state=GATE, including the first and last GATE cycles.
- States:
  - IDLE: if enable, go to SETTLE next cycle.
  - SETTLE: load down-counter with SETTLE_CYCLES-1 and clear the pulse counter. After exactly SETTLE_CYCLES cycles go to GATE. Edges in SETTLE are ignored.
  - GATE: lasts exactly GATE_CYCLES cycles; gate_active=1. The counter increments per edge and holds at 2^CNT_W-1 once reached, setting an internal ovf flag.
  - SCALE: one cycle. q = count >> SHIFT.
    - res_data = (q > 255) ? 255 : q[7:0].
    - res_sat = ovf | (q > 255).
    - res_ch = cur_ch.
    - res_valid rises at the end of this cycle.
  - PRESENT: res_valid=1. res_data, res_ch and res_sat are held stable until res_ready=1 at a clock edge.
    - On that edge, res_valid drops the next cycle and cur_ch advances: cur_ch = (cur_ch == NCH-1) ? 0 : cur_ch+1.
    - Next state is SETTLE if enable, else IDLE.
- Latency: GATE entry to res_valid is GATE_CYCLES+1 cycles. The minimum period per channel is SETTLE_CYCLES+GATE_CYCLES+2 cycles when res_ready is tied high.
- Enable drop:
  - In SETTLE or GATE: return to IDLE next cycle. Counter cleared, no result, cur_ch unchanged, so re-enable restarts the same channel.
  - In SCALE or PRESENT: the handshake completes, then the scheduler goes to IDLE.
- res_ready while res_valid=0 is ignored.
- Back-pressure: while in PRESENT no new gate starts and pulses are not counted.
- Pulse rate above clk/2 may lose edges; this is accepted.

Test Plan:
Bench parameters: NCH=2, GATE_CYCLES=100, SETTLE_CYCLES=4, SHIFT=2, res_ready=1 unless stated.
- 40 ch0 edges spaced 2 cycles inside GATE -> res_valid pulse; res_data=10, res_ch=0, res_sat=0; then cur_ch=1 and SETTLE begins the cycle after the handshake.
- 3 ch1 edges during SETTLE plus 8 edges in GATE -> res_data=2, res_ch=1; cur_ch wraps to 0.
- res_ready held low for 50 cycles after res_valid -> data/ch/sat stable, gate_active stays 0, ch1 edges uncounted; res_ready=1 -> res_valid low next cycle.
- SHIFT=0, GATE_CYCLES=1000, 300 edges every 3 cycles -> res_data=255, res_sat=1.
- enable dropped at GATE cycle 50 -> IDLE next cycle, busy=0, no res_valid, cur_ch unchanged; re-enable -> SETTLE on the same channel with the count restarted from 0.
- reset asserted mid-GATE and mid-PRESENT -> all outputs 0 immediately, cur_ch=0, IDLE after release.
